// File: rtl/dom_keccak_slice_sequencer.sv
// dom_keccak_slice_sequencer
//
// First-order masked Keccak chi-slice sequencer. It accepts one 25-bit slice
// (5 rows of 5 bits) as two Boolean shares plus fresh randomness. It feeds
// the rows, one per cycle, to an external first-order DOM 5-bit S-box, then
// collects the masked S-box results. The finished slice shares are presented
// through a valid/ready handshake.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input slice handshake (in_ready is high only in IDLE)
//   in_a, in_b        slice shares, row r = bits [5r+4:5r]
//   in_z              fresh randomness, row r uses bits [5r+4:5r]
//   sb_ax, sb_bx      share rows driven to the S-box (zero when not issuing)
//   sb_z              randomness row driven to the S-box (zero when not issuing)
//   sb_ay, sb_by      masked S-box results, valid SBOX_LAT cycles after issue
//   out_valid/out_ready result slice handshake
//   out_a, out_b      result shares, held stable while out_valid is high
//
// Shares A and B travel on separate register paths and are never combined
// here. Recombination happens only inside the DOM S-box.

module dom_keccak_slice_sequencer #(
    parameter int ROWS     = 5,
    parameter int SBOX_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ROWS*5-1:0]   in_a,
    input  logic [ROWS*5-1:0]   in_b,
    input  logic [ROWS*5-1:0]   in_z,
    output logic [4:0]          sb_ax,
    output logic [4:0]          sb_bx,
    output logic [4:0]          sb_z,
    input  logic [4:0]          sb_ay,
    input  logic [4:0]          sb_by,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROWS*5-1:0]   out_a,
    output logic [ROWS*5-1:0]   out_b
);

    localparam int         W        = ROWS * 5;
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    // Registered copies of the accepted slice and the assembled result shares.
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] z_q;
    logic [W-1:0] res_a;
    logic [W-1:0] res_b;

    // Row tracking pipeline. Stage 0 describes the row currently driven on
    // the S-box inputs, and its row field doubles as the issue counter. Each
    // later stage is one cycle older, so the tail stage names the row whose
    // S-box result is valid on sb_ay/sb_by in this cycle.
    logic       trk_v   [0:SBOX_LAT];
    logic [2:0] trk_row [0:SBOX_LAT];

    logic       cap_v;
    logic [2:0] cap_row;
    logic       cap_last;

    // Extracts one 5-bit row from a slice-wide vector.
    function automatic logic [4:0] get_row(input logic [W-1:0] v, input logic [2:0] r);
        return v[int'(r) * 5 +: 5];
    endfunction

    assign cap_v    = trk_v[SBOX_LAT];
    assign cap_row  = trk_row[SBOX_LAT];
    assign cap_last = cap_v && (cap_row == LAST_ROW);

    assign out_a = res_a;
    assign out_b = res_b;

    // Sequencer: one register process covers the FSM, the row-issue
    // datapath, the tracking pipeline and result capture. All handshake and
    // S-box outputs are registers, so the S-box inputs never glitch between
    // shares. The S-box inputs are forced to zero on every cycle that does
    // not issue a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            z_q       <= '0;
            res_a     <= '0;
            res_b     <= '0;
            sb_ax     <= '0;
            sb_bx     <= '0;
            sb_z      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i <= SBOX_LAT; i++) begin
                trk_v[i]   <= 1'b0;
                trk_row[i] <= '0;
            end
        end else begin
            // Age the tracking pipeline. Stage 0 is written by the FSM below.
            for (int i = 1; i <= SBOX_LAT; i++) begin
                trk_v[i]   <= trk_v[i-1];
                trk_row[i] <= trk_row[i-1];
            end

            // Capture the S-box result of the row that reaches the tail.
            if (cap_v) begin
                res_a[int'(cap_row) * 5 +: 5] <= sb_ay;
                res_b[int'(cap_row) * 5 +: 5] <= sb_by;
            end

            case (state)
                IDLE: begin
                    trk_v[0] <= 1'b0;
                    if (in_valid && in_ready) begin
                        // Row 0 goes out in the first cycle after the accept,
                        // so it is loaded straight from the input ports.
                        a_q        <= in_a;
                        b_q        <= in_b;
                        z_q        <= in_z;
                        sb_ax      <= in_a[4:0];
                        sb_bx      <= in_b[4:0];
                        sb_z       <= in_z[4:0];
                        trk_v[0]   <= 1'b1;
                        trk_row[0] <= '0;
                        in_ready   <= 1'b0;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (trk_row[0] == LAST_ROW) begin
                        sb_ax    <= '0;
                        sb_bx    <= '0;
                        sb_z     <= '0;
                        trk_v[0] <= 1'b0;
                        // With a zero-latency S-box the last row is captured
                        // on this same edge, and the block skips DRAIN.
                        if (cap_last) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state     <= DRAIN;
                        end
                    end else begin
                        sb_ax      <= get_row(a_q, trk_row[0] + 3'd1);
                        sb_bx      <= get_row(b_q, trk_row[0] + 3'd1);
                        sb_z       <= get_row(z_q, trk_row[0] + 3'd1);
                        trk_v[0]   <= 1'b1;
                        trk_row[0] <= trk_row[0] + 3'd1;
                    end
                end

                DRAIN: begin
                    trk_v[0] <= 1'b0;
                    if (cap_last) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    trk_v[0] <= 1'b0;
                    if (out_valid && out_ready) begin
                        // Wipe the share material so nothing from this slice
                        // stays in the registers after it has been handed on.
                        a_q       <= '0;
                        b_q       <= '0;
                        z_q       <= '0;
                        res_a     <= '0;
                        res_b     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dom_keccak_slice_sequencer.sv
// Testbench for dom_keccak_slice_sequencer. It contains a behavioural DOM
// S-box with one cycle of latency and a reference model of chi computed on
// the recombined slice.

module tb_dom_keccak_slice_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_a;
    logic [24:0] in_b;
    logic [24:0] in_z;
    logic [4:0]  sb_ax;
    logic [4:0]  sb_bx;
    logic [4:0]  sb_z;
    logic [4:0]  sb_ay;
    logic [4:0]  sb_by;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_a;
    logic [24:0] out_b;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int accept_cyc = 0;

    dom_keccak_slice_sequencer #(.ROWS(5), .SBOX_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_z      (in_z),
        .sb_ax     (sb_ax),
        .sb_bx     (sb_bx),
        .sb_z      (sb_z),
        .sb_ay     (sb_ay),
        .sb_by     (sb_by),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Free-running cycle counter, used to measure the distance between accepts.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference chi on an unmasked slice: y_i = x_i ^ (~x_{i+1} & x_{i+2}) per row.
    function automatic logic [24:0] chi_ref(input logic [24:0] x);
        logic [24:0] y;
        y = '0;
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 5; i++)
                y[5*r+i] = x[5*r+i] ^ (~x[5*r+(i+1)%5] & x[5*r+(i+2)%5]);
        return y;
    endfunction

    // First-order DOM chi S-box. Cross-domain terms are refreshed with z.
    function automatic logic [9:0] dom_sbox(input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] z);
        logic [4:0] ya;
        logic [4:0] yb;
        ya = '0;
        yb = '0;
        for (int i = 0; i < 5; i++) begin
            ya[i] = a[i] ^ (~a[(i+1)%5] & a[(i+2)%5]) ^ ((~a[(i+1)%5] & b[(i+2)%5]) ^ z[i]);
            yb[i] = b[i] ^ (b[(i+1)%5] & b[(i+2)%5]) ^ ((b[(i+1)%5] & a[(i+2)%5]) ^ z[i]);
        end
        return {ya, yb};
    endfunction

    // External S-box model with its one-cycle DOM register
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_ay <= '0;
            sb_by <= '0;
        end else begin
            {sb_ay, sb_by} <= dom_sbox(sb_ax, sb_bx, sb_z);
        end
    end

    // Hang protection
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one slice. Returns in cycle 1.
    task automatic applyStimulus(input logic [24:0] a, input logic [24:0] b,
                                 input logic [24:0] z);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_z     = z;
        in_valid = 1'b1;
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid   = 1'b0;
    endtask

    // From cycle 1, checks the row issue and masking of each cycle until
    // out_valid, then the latency and the recombined chi result.
    task automatic watchSlice(input logic [24:0] a, input logic [24:0] b,
                              input logic [24:0] z, output logic [24:0] ra,
                              output logic [24:0] rb);
        int k;
        logic [4:0] ea;
        logic [4:0] eb;
        logic [4:0] ez;
        k = 1;
        while (!out_valid && k < 20) begin
            if (k >= 1 && k <= 5) begin
                ea = 5'(a >> (5 * (k - 1)));
                eb = 5'(b >> (5 * (k - 1)));
                ez = 5'(z >> (5 * (k - 1)));
            end else begin
                ea = '0;
                eb = '0;
                ez = '0;
            end
            checkOutput("sb_row", 32'({sb_ax, sb_bx, sb_z}), 32'({ea, eb, ez}));
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            k++;
        end
        checkOutput("latency", 32'(k), 32'd7);
        checkOutput("sb_idle_done", 32'({sb_ax, sb_bx, sb_z}), 32'd0);
        checkOutput("in_ready_done", 32'(in_ready), 32'd0);
        checkOutput("chi", 32'(out_a ^ out_b), 32'(chi_ref(a ^ b)));
        ra = out_a;
        rb = out_b;
    endtask

    initial begin
        logic [24:0] a;
        logic [24:0] b;
        logic [24:0] z;
        logic [24:0] ra;
        logic [24:0] rb;
        logic        seen;
        int          prev;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_z      = '0;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out", 32'(out_a | out_b), 32'd0);
        checkOutput("rst_sb", 32'({sb_ax, sb_bx, sb_z}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Unmasked single bit in row 0
        $display("[TB] unmasked single row");
        applyStimulus(25'h0000001, 25'h0, 25'h0);
        watchSlice(25'h0000001, 25'h0, 25'h0, ra, rb);
        checkOutput("single_row", 32'(ra ^ rb), 32'h0000009);
        @(posedge clk); #1;
        checkOutput("hs_in_ready", 32'(in_ready), 32'd1);
        checkOutput("hs_out_valid", 32'(out_valid), 32'd0);

        // Masked all-ones with random z
        $display("[TB] masked all-ones");
        b = 25'h1555555;
        a = 25'h1FFFFFF ^ b;
        z = 25'h0ACE135;
        applyStimulus(a, b, z);
        watchSlice(a, b, z, ra, rb);
        checkOutput("all_ones", 32'(ra ^ rb), 32'h1FFFFFF);
        checkOutput("share_a_masked", 32'(ra == 25'h1FFFFFF), 32'd0);
        @(posedge clk); #1;

        // Backpressure: DONE holds and in_valid is ignored
        $display("[TB] backpressure");
        a = 25'($urandom);
        b = 25'($urandom);
        z = 25'($urandom);
        out_ready = 1'b0;
        applyStimulus(a, b, z);
        watchSlice(a, b, z, ra, rb);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = 25'($urandom);
            in_b     = 25'($urandom);
            in_z     = 25'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_out_a", 32'(out_a), 32'(ra));
            checkOutput("bp_out_b", 32'(out_b), 32'(rb));
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_sb_idle", 32'({sb_ax, sb_bx, sb_z}), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_clear", 32'(out_a | out_b), 32'd0);

        // Reset in the middle of ISSUE while row 2 is on the S-box inputs
        $display("[TB] reset mid-issue");
        a = 25'($urandom);
        b = 25'($urandom);
        z = 25'($urandom);
        applyStimulus(a, b, z);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_row2", 32'(sb_ax), 32'(5'(a >> 10)));
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_sb", 32'({sb_ax, sb_bx, sb_z}), 32'd0);
        checkOutput("mid_rst_out", 32'({out_valid, out_a, out_b}), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checkOutput("abort_no_valid", 32'(seen), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back random slices at the minimum initiation interval
        $display("[TB] back-to-back random");
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            a = 25'($urandom);
            b = 25'($urandom);
            z = 25'($urandom);
            applyStimulus(a, b, z);
            if (i > 0) checkOutput("accept_interval", 32'(accept_cyc - prev), 32'd8);
            prev = accept_cyc;
            watchSlice(a, b, z, ra, rb);
            @(posedge clk); #1;
            checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
            checkOutput("b2b_out_valid", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
